// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, head-field layout and NI state encoding.
// Used by the transmit and receive network interfaces and by destination decode.
package noc_pkg;

    localparam int FLIT_W    = 8;
    localparam int NODE_ID_W = 4;

    localparam int SRC_HI = 7;
    localparam int SRC_LO = 4;
    localparam int DST_HI = 3;
    localparam int DST_LO = 0;

    localparam logic [1:0] NI_ST_IDLE = 2'd0;
    localparam logic [1:0] NI_ST_HEAD = 2'd1;
    localparam logic [1:0] NI_ST_BODY = 2'd2;
    localparam logic [1:0] NI_ST_TAIL = 2'd3;

    typedef enum logic [1:0] {
        NI_IDLE = NI_ST_IDLE,
        NI_HEAD = NI_ST_HEAD,
        NI_BODY = NI_ST_BODY,
        NI_TAIL = NI_ST_TAIL
    } ni_state_t;

    function automatic logic [FLIT_W-1:0] make_head(input logic [NODE_ID_W-1:0] src,
                                                    input logic [NODE_ID_W-1:0] dst);
        logic [FLIT_W-1:0] f;
        f                = '0;
        f[SRC_HI:SRC_LO] = src;
        f[DST_HI:DST_LO] = dst;
        return f;
    endfunction

endpackage

// File: rtl/noc_credit_ctr.sv
// Credit counter for a downstream FIFO: starts full, saturates at DEPTH and at zero.
// Reusable by any upstream port that injects into a credited FIFO.
module noc_credit_ctr #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] count,
    output logic       credit_avail
);

    localparam logic [3:0] MAX = 4'(DEPTH);

    // A return and a spend on the same edge cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= MAX;
        end else if (inc && !dec && count != MAX) begin
            count <= count + 4'd1;
        end else if (dec && !inc && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign credit_avail = (count != 4'd0);

endmodule

// File: rtl/noc_ni_tx.sv
// Network-interface transmitter: serialises a core request into head/body flits under
// credit flow control. Define NOC_NI_TX_CHECKSUM_EN to append an XOR tail flit.
module noc_ni_tx
    import noc_pkg::*;
#(
    parameter int unsigned NODE_ID     = 0,
    parameter int unsigned PAYLOAD_LEN = 4,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [3:0] req_dst,
    output logic       req_ready,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    input  logic       credit_in,
    output logic [7:0] flit_out,
    output logic       flit_wr,
    output logic       busy,
    output logic       pkt_sent
);

    localparam logic [3:0] SRC_ID   = 4'(NODE_ID);
    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_LEN - 1);

    ni_state_t  state;
    logic [3:0] dst_q;
    logic [3:0] body_cnt;
    logic [3:0] credits;
    logic       credit_avail;
    logic       wr_en;
`ifdef NOC_NI_TX_CHECKSUM_EN
    logic [7:0] csum;
`endif

    noc_credit_ctr #(
        .DEPTH(FIFO_DEPTH)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .inc         (credit_in),
        .dec         (wr_en),
        .count       (credits),
        .credit_avail(credit_avail)
    );

    // wr_en is the flit write decision for the coming edge; it also spends the credit.
    always_comb begin
        wr_en = 1'b0;
        case (state)
            NI_HEAD: wr_en = credit_avail;
            NI_BODY: wr_en = pl_valid && credit_avail;
`ifdef NOC_NI_TX_CHECKSUM_EN
            NI_TAIL: wr_en = credit_avail;
`endif
            default: wr_en = 1'b0;
        endcase
    end

    assign req_ready = (state == NI_IDLE);
    assign busy      = (state != NI_IDLE);
    assign pl_ready  = (state == NI_BODY) && credit_avail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= NI_IDLE;
            dst_q    <= 4'd0;
            body_cnt <= 4'd0;
            flit_out <= 8'd0;
            flit_wr  <= 1'b0;
            pkt_sent <= 1'b0;
`ifdef NOC_NI_TX_CHECKSUM_EN
            csum     <= 8'd0;
`endif
        end else begin
            flit_wr  <= wr_en;
            pkt_sent <= 1'b0;
            case (state)
                NI_IDLE: begin
                    if (req_valid) begin
                        dst_q <= req_dst;
                        state <= NI_HEAD;
`ifdef NOC_NI_TX_CHECKSUM_EN
                        csum  <= 8'd0;
`endif
                    end
                end
                NI_HEAD: begin
                    if (credit_avail) begin
                        flit_out <= make_head(SRC_ID, dst_q);
                        body_cnt <= 4'd0;
                        state    <= NI_BODY;
                    end
                end
                NI_BODY: begin
                    if (wr_en) begin
                        flit_out <= pl_data;
                        body_cnt <= body_cnt + 4'd1;
`ifdef NOC_NI_TX_CHECKSUM_EN
                        csum     <= csum ^ pl_data;
                        if (body_cnt == LAST_IDX) begin
                            state <= NI_TAIL;
                        end
`else
                        if (body_cnt == LAST_IDX) begin
                            state    <= NI_IDLE;
                            pkt_sent <= 1'b1;
                        end
`endif
                    end
                end
`ifdef NOC_NI_TX_CHECKSUM_EN
                NI_TAIL: begin
                    if (credit_avail) begin
                        flit_out <= csum;
                        pkt_sent <= 1'b1;
                        state    <= NI_IDLE;
                    end
                end
`endif
                default: state <= NI_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_ni_tx.sv
// Self-checking bench for noc_ni_tx (NODE_ID=3, PAYLOAD_LEN=4, FIFO_DEPTH=8).
// A router model returns credits and tracks FIFO occupancy against the depth.
module tb_noc_ni_tx;

    localparam int         DEPTH = 8;
    localparam int         PLEN  = 4;
    localparam logic [3:0] NID   = 4'd3;
`ifdef NOC_NI_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_dst;
    logic       req_ready;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       credit_in;
    logic [7:0] flit_out;
    logic       flit_wr;
    logic       busy;
    logic       pkt_sent;

    noc_ni_tx #(
        .NODE_ID    (3),
        .PAYLOAD_LEN(PLEN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_dst  (req_dst),
        .req_ready(req_ready),
        .pl_valid (pl_valid),
        .pl_data  (pl_data),
        .pl_ready (pl_ready),
        .credit_in(credit_in),
        .flit_out (flit_out),
        .flit_wr  (flit_wr),
        .busy     (busy),
        .pkt_sent (pkt_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      dst;
        logic [3:0][7:0] pl;    // pl[0] is sent first
        int              gap;
        logic [7:0]      head;
        logic [7:0]      csum;
    } pkt_vec_t;

    pkt_vec_t   vecs[5];
    int         ntests;
    int         nfail;
    int         cyc;
    int         occ;
    int         sent_cnt;
    int         gap;
    int         gap_cnt;
    int         prev_last;
    bit         router_en;
    logic [7:0] flits[$];
    int         fcyc[$];
    logic [7:0] pl_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample at negedge, feed payload, drive the router credit return.
    task automatic tick(input bit man_credit);
        bit acc;
        acc = pl_valid && pl_ready;
        @(negedge clk);
        cyc++;
        if (flit_wr) begin
            flits.push_back(flit_out);
            fcyc.push_back(cyc);
            occ++;
            check("fifo_occupancy_le_depth", 32'(occ <= DEPTH), 32'd1);
        end
        if (pkt_sent) sent_cnt++;
        check("credit_count", 32'(dut.u_credit.count), 32'(DEPTH - occ));
        if (acc) begin
            void'(pl_q.pop_front());
            gap_cnt = gap;
        end
        if (pl_q.size() > 0 && gap_cnt == 0) begin
            pl_valid = 1'b1;
            pl_data  = pl_q[0];
        end else begin
            pl_valid = 1'b0;
            if (gap_cnt > 0) gap_cnt--;
        end
        credit_in = 1'b0;
        if (man_credit || (router_en && occ > 0 && $urandom_range(0, 1) == 1)) begin
            credit_in = 1'b1;
            if (occ > 0) occ--;
        end
    endtask

    task automatic start_pkt(input logic [3:0] dst, input logic [3:0][7:0] pl, input int g);
        int t;
        t = 0;
        while (!req_ready && t < 100) begin
            tick(1'b0);
            t++;
        end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        flits.delete();
        fcyc.delete();
        pl_q.delete();
        for (int i = 0; i < PLEN; i++) pl_q.push_back(pl[i]);
        gap       = g;
        gap_cnt   = 0;
        req_dst   = dst;
        req_valid = 1'b1;
        pl_valid  = 1'b1;
        pl_data   = pl_q[0];
        tick(1'b0);
        req_valid = 1'b0;
    endtask

    task automatic wait_sent();
        int t;
        int t0;
        t  = 0;
        t0 = sent_cnt;
        while (sent_cnt == t0 && t < 300) begin
            tick(1'b0);
            t++;
        end
        check("pkt_sent_seen", 32'(sent_cnt != t0), 32'd1);
        check("pkt_sent_with_last_flit", 32'(flit_wr), 32'd1);
        check("req_ready_after_last", 32'(req_ready), 32'd1);
        if (fcyc.size() > 0) prev_last = fcyc[fcyc.size()-1];
    endtask

    task automatic check_pkt(input logic [7:0] head, input logic [3:0][7:0] pl,
                             input logic [7:0] csum);
        logic [7:0] exp_q[$];
        exp_q.push_back(head);
        for (int i = 0; i < PLEN; i++) exp_q.push_back(pl[i]);
        if (CS != 0) exp_q.push_back(csum);
        check("pkt_flit_count", 32'(flits.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < flits.size(); i++) begin
            check($sformatf("flit[%0d]", i), 32'(flits[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic drain();
        int t;
        t         = 0;
        router_en = 1'b1;
        while ((occ > 0 || busy) && t < 300) begin
            tick(1'b0);
            t++;
        end
        router_en = 1'b0;
        tick(1'b0);
        check("drained_credits_full", 32'(dut.u_credit.count), 32'(DEPTH));
    endtask

    initial begin
        logic [3:0][7:0] rp;
        logic [3:0]      rd;
        logic [7:0]      rc;
        int              t;

        ntests    = 0;
        nfail     = 0;
        cyc       = 0;
        occ       = 0;
        sent_cnt  = 0;
        gap       = 0;
        gap_cnt   = 0;
        prev_last = 0;
        router_en = 1'b0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_dst   = 4'd0;
        pl_valid  = 1'b0;
        pl_data   = 8'd0;
        credit_in = 1'b0;

        vecs[0] = '{dst: 4'hA, pl: {8'h44, 8'h33, 8'h22, 8'h11}, gap: 0, head: 8'h3A, csum: 8'h44};
        vecs[1] = '{dst: 4'h0, pl: {8'hFF, 8'h00, 8'hFF, 8'h00}, gap: 0, head: 8'h30, csum: 8'h00};
        vecs[2] = '{dst: 4'hF, pl: {8'hEF, 8'hBE, 8'hAD, 8'hDE}, gap: 2, head: 8'h3F, csum: 8'h22};
        vecs[3] = '{dst: 4'h3, pl: {8'h08, 8'h04, 8'h02, 8'h01}, gap: 1, head: 8'h33, csum: 8'h0F};
        vecs[4] = '{dst: 4'hC, pl: {8'hC3, 8'h3C, 8'h5A, 8'hA5}, gap: 0, head: 8'h3C, csum: 8'h00};

        repeat (2) @(negedge clk);
        check("rst_flit_out", 32'(flit_out), 32'd0);
        check("rst_flit_wr", 32'(flit_wr), 32'd0);
        check("rst_pkt_sent", 32'(pkt_sent), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_pl_ready", 32'(pl_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_credits", 32'(dut.u_credit.count), 32'(DEPTH));
        rst = 1'b0;

        // Single packet with no credit return, then table packets back to back.
        start_pkt(vecs[0].dst, vecs[0].pl, vecs[0].gap);
        wait_sent();
        check_pkt(vecs[0].head, vecs[0].pl, vecs[0].csum);
        if (fcyc.size() > 0) check("consecutive_flits", 32'(fcyc[fcyc.size()-1] - fcyc[0]), 32'(PLEN + CS));
        check("credits_after_first", 32'(dut.u_credit.count), 32'(3 - CS));
        router_en = 1'b1;
        for (int k = 1; k < 5; k++) begin
            int last0;
            last0 = prev_last;
            start_pkt(vecs[k].dst, vecs[k].pl, vecs[k].gap);
            wait_sent();
            check_pkt(vecs[k].head, vecs[k].pl, vecs[k].csum);
            if (k == 1 && fcyc.size() > 0) check("b2b_head_gap", 32'(fcyc[0] - last0), 32'd2);
        end

        // Credit exhaustion: one full packet without returns leaves 3-CS credits.
        drain();
        start_pkt(4'h5, {8'h04, 8'h03, 8'h02, 8'h01}, 0);
        wait_sent();
        check_pkt(8'h35, {8'h04, 8'h03, 8'h02, 8'h01}, 8'h04);
        start_pkt(4'h6, {8'h9D, 8'h9C, 8'h9B, 8'h9A}, 0);
        repeat (8) tick(1'b0);
        check("stall_flit_count", 32'(flits.size()), 32'(3 - CS));
        check("stall_pl_ready", 32'(pl_ready), 32'd0);
        check("stall_flit_wr", 32'(flit_wr), 32'd0);
        tick(1'b1);
        tick(1'b0);
        check("credit_return_no_flit_yet", 32'(flit_wr), 32'd0);
        tick(1'b0);
        check("credit_return_one_flit", 32'(flit_wr), 32'd1);
        repeat (4) tick(1'b0);
        check("credit_return_exactly_one", 32'(flits.size()), 32'(4 - CS));
        check("restall_pl_ready", 32'(pl_ready), 32'd0);
        router_en = 1'b1;
        wait_sent();
        // 9A^9B^9C^9D = 0x00
        check_pkt(8'h36, {8'h9D, 8'h9C, 8'h9B, 8'h9A}, 8'h00);

        // Credit return while already full must saturate.
        drain();
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        check("saturate_at_depth", 32'(dut.u_credit.count), 32'(DEPTH));

        // Asynchronous reset while the second body flit is on the wire.
        router_en = 1'b1;
        start_pkt(4'h9, {8'h88, 8'h77, 8'h66, 8'h55}, 0);
        t = 0;
        while (flits.size() < 3 && t < 100) begin
            tick(1'b0);
            t++;
        end
        check("mid_pkt_second_body", 32'(flit_wr && flit_out == 8'h66), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_flit_wr", 32'(flit_wr), 32'd0);
        check("async_rst_flit_out", 32'(flit_out), 32'd0);
        check("async_rst_req_ready", 32'(req_ready), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_pl_ready", 32'(pl_ready), 32'd0);
        check("async_rst_credits", 32'(dut.u_credit.count), 32'(DEPTH));
        occ       = 0;
        pl_q.delete();
        pl_valid  = 1'b0;
        req_valid = 1'b0;
        credit_in = 1'b0;
        gap_cnt   = 0;
        @(negedge clk);
        rst = 1'b0;
        start_pkt(vecs[0].dst, vecs[0].pl, 0);
        wait_sent();
        check_pkt(vecs[0].head, vecs[0].pl, vecs[0].csum);

        // Random traffic with random stalls on both sides.
        for (int p = 0; p < 100; p++) begin
            rd = 4'($urandom_range(0, 15));
            rp = $urandom();
            rc = rp[0] ^ rp[1] ^ rp[2] ^ rp[3];
            start_pkt(rd, rp, $urandom_range(0, 2));
            wait_sent();
            check_pkt({NID, rd}, rp, rc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
